// File: rtl/conv_pkg.sv
// Shared constants and FSM encoding for the conv2 input feeder.
package conv_pkg;
  localparam int IN_W  = 14;
  localparam int IN_H  = 14;
  localparam int K     = 5;
  localparam int NUM_W = 225;
  localparam int DW    = 16;
  localparam int WW    = 8;
  localparam int OUT_W = IN_W - K + 1;
  localparam int OUT_H = IN_H - K + 1;

  typedef enum logic [2:0] {
    IDLE,
    WLOAD,
    WWAIT,
    FMLOAD,
    STREAM
  } state_t;
endpackage

// File: rtl/fmap_buf.sv
// Feature-map store: one write port, registered read port with enable so a stalled read holds.
module fmap_buf #(
  parameter int DEPTH = 196,
  parameter int WIDTH = 48,
  parameter int AW    = 8
) (
  input  logic             i_clk,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             re,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (we) mem[wr_addr] <= wr_data;
    if (re) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/conv2_feeder.sv
// Drives conv2: streams filter bytes once, then per frame buffers a 3-channel map
// and replays every KxK stride-1 window, kx fastest.
module conv2_feeder #(
  parameter int IN_W  = conv_pkg::IN_W,
  parameter int IN_H  = conv_pkg::IN_H,
  parameter int K     = conv_pkg::K,
  parameter int NUM_W = conv_pkg::NUM_W,
  parameter int DW    = conv_pkg::DW,
  parameter int WW    = conv_pkg::WW
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  output logic [7:0]    w_addr,
  input  logic [WW-1:0] w_rdata,
  output logic [WW-1:0] filter,
  output logic          weight_valid,
  input  logic          weight_done,
  input  logic          fm_valid,
  input  logic [DW-1:0] fm_ch0,
  input  logic [DW-1:0] fm_ch1,
  input  logic [DW-1:0] fm_ch2,
  output logic          fm_ready,
  input  logic          dst_ready,
  output logic [DW-1:0] data_ch0,
  output logic [DW-1:0] data_ch1,
  output logic [DW-1:0] data_ch2,
  output logic          i_valid,
  output logic          frame_done
);
  import conv_pkg::*;

  localparam int OW   = IN_W - K + 1;
  localparam int OH   = IN_H - K + 1;
  localparam int NPIX = IN_W * IN_H;
  localparam int AW   = $clog2(NPIX);
  localparam int CW   = $clog2((IN_W > IN_H) ? IN_W : IN_H) + 1;

  localparam logic [7:0]    W_LAST   = 8'(NUM_W - 1);
  localparam logic [AW-1:0] PIX_LAST = AW'(NPIX - 1);
  localparam logic [CW-1:0] K_LAST   = CW'(K - 1);
  localparam logic [CW-1:0] OX_LAST  = CW'(OW - 1);
  localparam logic [CW-1:0] OY_LAST  = CW'(OH - 1);

  state_t state, state_nx;

  logic [1:0]          w_vld_pipe;
  logic [AW-1:0]       wr_idx;
  logic [CW-1:0]       oy, ox, ky, kx;
  logic                issue_done;
  logic                issue, at_end, we;
  logic [AW-1:0]       rd_addr;
  logic [2:0][DW-1:0]  wr_pix, rd_pix;
  logic                s1_vld, s1_last, i_last;

  assign weight_valid = w_vld_pipe[1];
  assign we      = (state == FMLOAD) && fm_valid;
  assign wr_pix  = {fm_ch0, fm_ch1, fm_ch2};
  assign issue   = (state == STREAM) && !issue_done && dst_ready;
  assign at_end  = (kx == K_LAST) && (ky == K_LAST) && (ox == OX_LAST) && (oy == OY_LAST);
  assign rd_addr = AW'((32'(oy) + 32'(ky)) * IN_W + 32'(ox) + 32'(kx));

  fmap_buf #(.DEPTH(NPIX), .WIDTH(3*DW), .AW(AW)) u_buf (
    .i_clk   (i_clk),
    .we      (we),
    .wr_addr (wr_idx),
    .wr_data (wr_pix),
    .re      (dst_ready),
    .rd_addr (rd_addr),
    .rd_data (rd_pix)
  );

  always_comb begin
    state_nx = state;
    fm_ready = 1'b0;
    case (state)
      IDLE:   if (i_start) state_nx = WLOAD;
      WLOAD:  if (w_addr == W_LAST) state_nx = WWAIT;
      WWAIT:  if (weight_done) state_nx = FMLOAD;
      FMLOAD: begin
        fm_ready = 1'b1;
        if (fm_valid && wr_idx == PIX_LAST) state_nx = STREAM;
      end
      STREAM: if (i_valid && i_last) state_nx = FMLOAD;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      w_addr     <= '0;
      w_vld_pipe <= '0;
      filter     <= '0;
      wr_idx     <= '0;
      {oy, ox, ky, kx} <= '0;
      issue_done <= 1'b0;
      s1_vld     <= 1'b0;
      s1_last    <= 1'b0;
      i_valid    <= 1'b0;
      i_last     <= 1'b0;
      data_ch0   <= '0;
      data_ch1   <= '0;
      data_ch2   <= '0;
      frame_done <= 1'b0;
    end else begin
      state <= state_nx;

      // Memory returns data one cycle after the address, so qualify it two stages later.
      w_vld_pipe <= {w_vld_pipe[0], state == WLOAD};
      if (w_vld_pipe[0]) filter <= w_rdata;
      if (state == IDLE) w_addr <= '0;
      else if (state == WLOAD && w_addr != W_LAST) w_addr <= w_addr + 1'b1;

      if (we) wr_idx <= (wr_idx == PIX_LAST) ? '0 : wr_idx + 1'b1;

      if (state != STREAM) issue_done <= 1'b0;
      else if (issue && at_end) issue_done <= 1'b1;

      if (issue) begin
        kx <= (kx == K_LAST) ? '0 : kx + 1'b1;
        if (kx == K_LAST) begin
          ky <= (ky == K_LAST) ? '0 : ky + 1'b1;
          if (ky == K_LAST) begin
            ox <= (ox == OX_LAST) ? '0 : ox + 1'b1;
            if (ox == OX_LAST) oy <= (oy == OY_LAST) ? '0 : oy + 1'b1;
          end
        end
      end

      // Both stages advance together; a low dst_ready freezes them and drops i_valid.
      if (dst_ready) begin
        s1_vld   <= issue;
        s1_last  <= issue && at_end;
        i_valid  <= s1_vld;
        i_last   <= s1_last;
        data_ch0 <= rd_pix[2];
        data_ch1 <= rd_pix[1];
        data_ch2 <= rd_pix[0];
      end else begin
        i_valid <= 1'b0;
      end

      frame_done <= i_valid && i_last;
    end
  end
endmodule

// File: tb/tb_conv2_feeder.sv
// Scoreboard bench for conv2_feeder: directed weight load, frames, backpressure, reset.
module tb_conv2_feeder;
  localparam int IN_W = 14, IN_H = 14, K = 5, NUM_W = 225, DW = 16, WW = 8;
  localparam int OUT_W = 10, OUT_H = 10, NPIX = 196, NSAMP = 2500;

  logic          clk = 1'b0;
  logic          rst, start, weight_done, fm_valid, dst_ready;
  logic [7:0]    w_addr;
  logic [WW-1:0] w_rdata = '0, filter;
  logic          weight_valid, fm_ready, i_valid, frame_done;
  logic [DW-1:0] fm_ch0, fm_ch1, fm_ch2, data_ch0, data_ch1, data_ch2;

  conv2_feeder dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .w_addr(w_addr), .w_rdata(w_rdata), .filter(filter), .weight_valid(weight_valid),
    .weight_done(weight_done), .fm_valid(fm_valid),
    .fm_ch0(fm_ch0), .fm_ch1(fm_ch1), .fm_ch2(fm_ch2), .fm_ready(fm_ready),
    .dst_ready(dst_ready), .data_ch0(data_ch0), .data_ch1(data_ch1), .data_ch2(data_ch2),
    .i_valid(i_valid), .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) w_rdata <= w_addr ^ 8'h5A;

  int tests = 0, fails = 0;
  logic [7:0]  wq[$];
  logic [47:0] sq[$];

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [47:0] pix(input int p, input int off);
    logic [15:0] v;
    v = 16'(p + off);
    return {v, 16'h1000 | v, 16'h2000 | v};
  endfunction

  // Monitor
  int nsamp = 0, wv_run = 0, wv_total = 0, fd_cnt = 0, cyc = 0, first_cyc = 0, last_cyc = 0;
  logic prev_dst = 1'b0, prev_iv = 1'b0;
  logic [DW-1:0] first6 [6];
  logic [DW-1:0] last0, last2;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      nsamp  = 0;
      wv_run = 0;
    end else begin
      if (weight_valid) begin
        wv_run++;
        wv_total++;
        if (wq.size() == 0) begin
          tests++; fails++;
          $display("FAIL spurious_weight_valid: got filter %0h expected no weight", filter);
        end else chk("filter", filter, wq.pop_front());
      end else if (wv_run != 0) begin
        chk("weight_valid_run", wv_run, NUM_W);
        wv_run = 0;
      end
      if (i_valid) begin
        chk("i_valid_after_dst_ready", prev_dst, 1);
        if (sq.size() == 0) begin
          tests++; fails++;
          $display("FAIL spurious_sample: got %0h expected no sample", {data_ch0, data_ch1, data_ch2});
        end else chk("sample", {data_ch0, data_ch1, data_ch2}, sq.pop_front());
        if (nsamp < 6) first6[nsamp] = data_ch0;
        if (nsamp == 0) first_cyc = cyc;
        last_cyc = cyc;
        last0 = data_ch0;
        last2 = data_ch2;
        nsamp++;
      end
      if (frame_done) begin
        chk("frame_done_follows_sample", prev_iv, 1);
        chk("frame_sample_count", nsamp, NSAMP);
        nsamp = 0;
        fd_cnt++;
      end
    end
    prev_dst = dst_ready;
    prev_iv  = i_valid;
  end

  task automatic push_frame(input int off);
    for (int oy = 0; oy < OUT_H; oy++)
      for (int ox = 0; ox < OUT_W; ox++)
        for (int ky = 0; ky < K; ky++)
          for (int kx = 0; kx < K; kx++)
            sq.push_back(pix((oy + ky) * IN_W + ox + kx, off));
  endtask

  task automatic load_fm(input int off, input int gap);
    for (int p = 0; p < NPIX; p++) begin
      if (gap > 1) begin
        fm_valid = 1'b0;
        repeat (gap - 1) begin @(posedge clk); #1; end
      end
      fm_valid = 1'b1;
      {fm_ch0, fm_ch1, fm_ch2} = pix(p, off);
      if (p == NPIX - 1) chk("fm_ready_at_last_write", fm_ready, 1);
      @(posedge clk); #1;
    end
    fm_valid = 1'b0;
    chk("fm_ready_after_last_write", fm_ready, 0);
  endtask

  task automatic wait_frames(input int target, input bit bp, input int budget);
    int n = 0;
    while (fd_cnt < target && n < budget) begin
      if (bp) dst_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    dst_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk("frames_done", fd_cnt, target);
    chk("scoreboard_drained", sq.size(), 0);
  endtask

  task automatic weight_load(input int expect_total);
    for (int n = 0; n < NUM_W; n++) wq.push_back(8'(n) ^ 8'h5A);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (235) @(posedge clk);
    #1;
    chk("weight_total", wv_total, expect_total);
    chk("weight_queue_empty", wq.size(), 0);
    chk("w_addr_final", w_addr, NUM_W - 1);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; weight_done = 1'b0; fm_valid = 1'b0; dst_ready = 1'b1;
    fm_ch0 = '0; fm_ch1 = '0; fm_ch2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_weight_valid", weight_valid, 0);
    chk("rst_i_valid", i_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_fm_ready", fm_ready, 0);
    chk("rst_w_addr", w_addr, 0);
    chk("rst_filter", filter, 0);
    chk("rst_data", {data_ch0, data_ch1, data_ch2}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Weights, then hold in WWAIT; a stray i_start there must be ignored.
    weight_load(NUM_W);
    chk("wwait_fm_ready", fm_ready, 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("wwait_hold", fm_ready, 0);
    weight_done = 1'b1;
    @(posedge clk); #1;
    weight_done = 1'b0;
    chk("fmload_after_weight_done", fm_ready, 1);

    // Frame 1: contiguous load, no stall.
    load_fm(0, 1);
    push_frame(0);
    @(posedge clk); #1;
    chk("latency_cycle1", i_valid, 0);
    @(posedge clk); #1;
    chk("latency_cycle2", i_valid, 1);
    wait_frames(1, 1'b0, 3000);
    for (int i = 0; i < 5; i++) chk("window0_ch0", first6[i], i);
    chk("window0_sample6", first6[5], 14);
    chk("last_sample_ch0", last0, 195);
    chk("last_sample_ch2", last2, 16'h2000 | 16'd195);
    chk("no_bubble_span", last_cyc - first_cyc + 1, NSAMP);

    // Frame 2: gapped upstream, random backpressure, fm_valid during STREAM.
    load_fm(0, 3);
    push_frame(0);
    for (int i = 0; i < 3; i++) begin
      fm_valid = 1'b1;
      {fm_ch0, fm_ch1, fm_ch2} = {3{16'hDEAD}};
      dst_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    fm_valid = 1'b0;
    wait_frames(2, 1'b1, 8000);

    // Frame 3: new map, no weight reload.
    load_fm(256, 1);
    push_frame(256);
    wait_frames(3, 1'b0, 3000);
    chk("no_weight_reload", wv_total, NUM_W);

    // Frame 4: reset at sample 700.
    load_fm(0, 1);
    push_frame(0);
    n = 0;
    while (nsamp < 700 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reached_sample_700", nsamp >= 700, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_i_valid", i_valid, 0);
    chk("midrst_fm_ready", fm_ready, 0);
    chk("midrst_w_addr", w_addr, 0);
    chk("midrst_frame_done", frame_done, 0);
    rst = 1'b0;
    sq.delete();
    repeat (5) @(posedge clk);
    #1;
    chk("midrst_no_frame_done", fd_cnt, 3);
    chk("idle_fm_ready", fm_ready, 0);
    weight_load(2 * NUM_W);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
